// File: rtl/half_adder.sv
// Bit-wise half adder lanes (sum = a ^ b, carry = a & b) with an optional registered, valid-qualified copy.
// Latency: combinational outputs 0 cycles; sum_q/carry_q/out_valid 1 cycle. Optional macro: HALF_ADDER_STATS_EN.
// Backpressure: none; every in_valid beat is accepted.
module half_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid
`ifdef HALF_ADDER_STATS_EN
    ,
    output logic [31:0]      carry_cnt
`endif
);

    // Pure bitwise operators keep lanes isolated, so X/Z on one lane stays in that lane.
    assign sum   = a ^ b;
    assign carry = a & b;

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q     <= '0;
                carry_q   <= '0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    sum_q   <= sum;
                    carry_q <= carry;
                end
            end
        end
    end else begin : g_noreg
        assign sum_q     = '0;
        assign carry_q   = '0;
        assign out_valid = 1'b0;
    end

`ifdef HALF_ADDER_STATS_EN
    // Counts accepted beats that produced at least one carry; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if (in_valid && (|carry) && (carry_cnt != 32'hFFFF_FFFF)) begin
            carry_cnt <= carry_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: 16-lane registered instance plus an 8-lane instance without the register stage.
module tb_half_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a, b;
    logic [15:0] sum, carry, sum_q, carry_q;
    logic        out_valid;
    logic [7:0]  a8, b8;
    logic [7:0]  sum8, carry8, sum_q8, carry_q8;
    logic        out_valid8;
`ifdef HALF_ADDER_STATS_EN
    logic [31:0] carry_cnt, carry_cnt8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    half_adder #(.WIDTH(16), .REG_OUT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q), .out_valid(out_valid)
`ifdef HALF_ADDER_STATS_EN
        , .carry_cnt(carry_cnt)
`endif
    );

    half_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_noreg (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(in_valid),
        .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8), .out_valid(out_valid8)
`ifdef HALF_ADDER_STATS_EN
        , .carry_cnt(carry_cnt8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] es, ec;
        logic [1:0]  lane;
        logic [1:0]  tt_a [4];
        logic [1:0]  tt_s [4];
        tt_a = '{2'b00, 2'b01, 2'b10, 2'b11};
        tt_s = '{2'b00, 2'b10, 2'b10, 2'b01}; // {sum, carry}

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; a8 = '0; b8 = '0;
        #1;
        chk("reset_sum_q", 32'(sum_q), 32'h0);
        chk("reset_carry_q", 32'(carry_q), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
`ifdef HALF_ADDER_STATS_EN
        chk("reset_carry_cnt", carry_cnt, 32'h0);
`endif

        // Truth table on lane 0 while reset is held: combinational path must not care.
        for (int i = 0; i < 4; i++) begin
            a = {15'h0, tt_a[i][1]};
            b = {15'h0, tt_a[i][0]};
            #1;
            chk($sformatf("tt%0d_sum", i), 32'(sum), {31'h0, tt_s[i][1]});
            chk($sformatf("tt%0d_carry", i), 32'(carry), {31'h0, tt_s[i][0]});
        end

        a8 = 8'hF0; b8 = 8'h3C;
        a = 16'hF0F0; b = 16'h3C3C;
        #1;
        chk("w8_sum", 32'(sum8), 32'hCC);
        chk("w8_carry", 32'(carry8), 32'h30);
        chk("w16_sum", 32'(sum), 32'hCCCC);
        chk("w16_carry", 32'(carry), 32'h3030);

        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; a = 16'h0001; b = 16'h0001;
        @(posedge clk); #1;
        chk("cap11_sum_q", 32'(sum_q), 32'h0);
        chk("cap11_carry_q", 32'(carry_q), 32'h1);
        chk("cap11_out_valid", 32'(out_valid), 32'h1);
        chk("noreg_out_valid", 32'(out_valid8), 32'h0);
        chk("noreg_carry_q", 32'(carry_q8), 32'h0);

        @(negedge clk);
        in_valid = 1'b0; a = 16'h0001; b = 16'h0000;
        @(posedge clk); #1;
        chk("hold_out_valid", 32'(out_valid), 32'h0);
        chk("hold_sum_q", 32'(sum_q), 32'h0);
        chk("hold_carry_q", 32'(carry_q), 32'h1);

        @(negedge clk);
        in_valid = 1'b1; a = 16'hA5C3; b = 16'h0FF0;
        @(posedge clk); #1;
        chk("multi_sum_q", 32'(sum_q), 32'hAA33);
        chk("multi_carry_q", 32'(carry_q), 32'h05C0);
        chk("multi_out_valid", 32'(out_valid), 32'h1);

        // Reset between edges with a valid result sitting in the register.
        #2;
        rst = 1'b1; a = 16'h00FF; b = 16'h0F0F;
        #1;
        chk("midrst_sum_q", 32'(sum_q), 32'h0);
        chk("midrst_carry_q", 32'(carry_q), 32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_sum", 32'(sum), 32'h0FF0);
        chk("midrst_carry", 32'(carry), 32'h000F);

        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; a = 16'h0003; b = 16'h0003;
        @(posedge clk); #1;
        chk("release_out_valid", 32'(out_valid), 32'h1);
        chk("release_carry_q", 32'(carry_q), 32'h3);

        // Carry statistics: 5 carrying beats, 3 non-carrying beats.
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'h0001; b = (i < 5) ? 16'h0001 : 16'h0000;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stats_last_sum_q", 32'(sum_q), 32'h1);
`ifdef HALF_ADDER_STATS_EN
        chk("stats_carry_cnt", carry_cnt, 32'd5);
`endif

        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom); b = 16'($urandom);
            #1;
            es = '0; ec = '0;
            for (int i = 0; i < 16; i++) begin
                lane = {1'b0, a[i]} + {1'b0, b[i]};
                es[i] = lane[0];
                ec[i] = lane[1];
            end
            chk("rand_sum_carry", {sum, carry}, {es, ec});
            chk("rand_exclusive", 32'(sum & carry), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bit-wise half adder: sum = a XOR b, carry = a AND b.
- Combinational outputs are available immediately, with no clock dependency.
- A registered copy with valid qualification is provided for pipelined datapaths.
- Leaf arithmetic cell, instantiated inside wider adders and counters.

Parameters:
- WIDTH, 1, number of independent half-adder lanes; legal range 1..64.
- REG_OUT, 1, 1 = build the registered output stage; 0 = registered outputs tied to 0 and out_valid tied to 0.

Ports:
- clk  input  1  rising-edge clock for the registered stage.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- in_valid  input  1  qualifies a/b for capture into the registered stage.
- sum  output  WIDTH  combinational a ^ b.
- carry  output  WIDTH  combinational a & b.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  WIDTH  registered carry.
- out_valid  output  1  registered in_valid.

Behaviour:
- Combinational path:
  - sum[i] = a[i] ^ b[i]; carry[i] = a[i] & b[i], for every lane i.
  - Lanes are independent; no carry propagates between lanes.
  - Zero-cycle latency, purely combinational.
  - Unaffected by clk and rst; valid even while rst is high or clk is stopped.
  - X/Z on an input lane must not corrupt other lanes.
- Truth table per lane (a b -> sum carry): 00->0 0, 01->1 0, 10->1 0, 11->0 1.
- Registered path (REG_OUT=1):
  - On each rising clk edge with rst low: out_valid <= in_valid.
  - If in_valid = 1: sum_q <= a ^ b and carry_q <= a & b.
  - If in_valid = 0: sum_q and carry_q hold their previous values.
  - Latency is 1 cycle from in_valid to out_valid.
  - No backpressure; every valid input is accepted.
- Reset:
  - rst high immediately clears sum_q, carry_q and out_valid to 0, without waiting for a clk edge.
  - Release takes effect at the first clk edge after rst deasserts.
  - Reset asserted mid-stream drops any in-flight registered result.
- Invariant: carry and sum are never both 1 in the same lane (combinational and registered).

Optional Feature:
- Macro: HALF_ADDER_STATS_EN.
- Defined:
  - Adds output carry_cnt [31:0], counting clk cycles where in_valid = 1 and any carry lane = 1.
  - Saturates at 0xFFFFFFFF.
  - Cleared asynchronously by rst.
- Not defined: port absent and no counter logic built; all other behaviour identical.

Test Plan:
- WIDTH=1, rst=0, apply a/b = 00, 01, 10, 11 at 10-time-unit steps, checking before any clk edge -> sum/carry = 0/0, 1/0, 1/0, 0/1.
- WIDTH=8, a=8'hF0, b=8'h3C -> sum=8'hCC, carry=8'h30; no inter-lane carry.
- Registered path: in_valid=1, a=1, b=1 at edge N -> at edge N: sum_q=0, carry_q=1, out_valid=1. Next edge with in_valid=0 -> out_valid=0, sum_q/carry_q held.
- Assert rst between clk edges while out_valid=1 -> sum_q, carry_q, out_valid go to 0 immediately. Combinational sum/carry still track a/b during reset.
- HALF_ADDER_STATS_EN defined, WIDTH=1, 5 valid cycles with a=b=1 plus 3 valid cycles with a=1, b=0 -> carry_cnt=5.
- Randomised 1000 vectors, WIDTH=16 -> sum+2*carry equals lane-wise a+b; never sum&carry != 0.
